// File: rtl/hex_display_ctrl_if.sv
// Control/data bundle between the host side and the hex display controller.
interface hex_display_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   Data;
  logic                  BlankLZ;
  logic                  BlinkEn;
  logic [DIGITS-1:0]     BlinkMask;
  logic                  Pending;
  logic [7*DIGITS-1:0]   HexOut;
  logic [6:0]            ScanSeg;
  logic [DIGITS-1:0]     ScanAn;

  modport master (
    output Load, Data, BlankLZ, BlinkEn, BlinkMask,
    input  Pending, HexOut, ScanSeg, ScanAn
  );

  modport slave (
    input  Load, Data, BlankLZ, BlinkEn, BlinkMask,
    output Pending, HexOut, ScanSeg, ScanAn
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment controller: shadowed value committed on frame boundaries,
// parallel glyphs plus a multiplexed scan port, leading-zero blanking and blink.
module hex_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input logic               Clk,
  input logic               Reset,
  hex_display_ctrl_if.slave bus
);
  localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW  = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  logic [DIGITS-1:0][3:0] shadow, disp;
  logic                   pending;
  logic [SCW-1:0]         scan_cnt;
  logic [IW-1:0]          scan_idx;
  logic [BCW-1:0]         blink_cnt;
  logic                   blink_on;
  logic [DIGITS-1:0][6:0] hex_q, hex_n;
  logic [6:0]             seg_q, seg_n;
  logic [DIGITS-1:0]      an_q, an_n;
  logic                   scan_term, blink_term, frame, upper_zero;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001; 4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010; 4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100; 4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000; 4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000; 4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000; 4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001; 4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000; default: glyph = 7'b0111000;
    endcase
  endfunction

  assign scan_term  = (scan_cnt  == SCW'(SCAN_DIV - 1));
  assign blink_term = (blink_cnt == BCW'(BLINK_DIV - 1));
  assign frame      = scan_term && (scan_idx == IW'(DIGITS - 1));

  // Walk digits from the top so upper_zero tracks "this and all higher nibbles are zero".
  always_comb begin
    hex_n      = '0;
    an_n       = '1;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp[i] == 4'h0);
      if ((bus.BlankLZ && i > 0 && upper_zero) ||
          (bus.BlinkEn && bus.BlinkMask[i] && !blink_on))
        hex_n[i] = 7'b1111111;
      else
        hex_n[i] = glyph(disp[i]);
    end
    seg_n          = hex_n[scan_idx];
    an_n[scan_idx] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow    <= '0;
      disp      <= '0;
      pending   <= 1'b0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      hex_q     <= '1;
      seg_q     <= '1;
      an_q      <= '1;
    end else begin
      if (bus.Load) shadow <= bus.Data;
      // A load landing on the boundary bypasses the shadow so it is never held a full frame.
      if (frame && bus.Load) begin
        disp    <= bus.Data;
        pending <= 1'b0;
      end else if (frame && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end else if (bus.Load) begin
        pending <= 1'b1;
      end

      if (scan_term) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_term) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      hex_q <= hex_n;
      seg_q <= seg_n;
      an_q  <= an_n;
    end
  end

  assign bus.Pending = pending;
  assign bus.HexOut  = hex_q;
  assign bus.ScanSeg = seg_q;
  assign bus.ScanAn  = an_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_DIV=8 (16-cycle frame).
module tb_hex_display_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  hex_display_ctrl_if #(.DIGITS(4)) bus();
  hex_display_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000, GA = 7'b0001000, GC = 7'b0110001;
  localparam logic [6:0] GF = 7'b0111000, BL = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Data presented now is captured on the next edge.
  task automatic load(input logic [15:0] d);
    bus.Data = d;
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
  endtask

  initial begin
    logic [3:0]      an_exp;
    logic [3:0][6:0] e;
    bus.Load = 1'b0; bus.Data = '0; bus.BlankLZ = 1'b0;
    bus.BlinkEn = 1'b0; bus.BlinkMask = '0;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_hex", bus.HexOut, 28'hfffffff);
    chk("rst_seg", bus.ScanSeg, BL);
    chk("rst_an", bus.ScanAn, 4'b1111);
    chk("rst_pend", bus.Pending, 1'b0);

    Reset = 1'b0;
    cyc = 0;
    tick();
    chk("first_hex", bus.HexOut, {G0, G0, G0, G0});
    chk("first_pend", bus.Pending, 1'b0);

    while (cyc <= 16) begin
      an_exp = ~(4'b0001 << (((cyc - 1) / 4) % 4));
      chk("scan_an", bus.ScanAn, an_exp);
      chk("scan_seg", bus.ScanSeg, G0);
      tick();
    end

    run_to(20);
    load(16'h12AF);
    chk("mid_pend", bus.Pending, 1'b1);
    chk("mid_hold", bus.HexOut, {G0, G0, G0, G0});
    run_to(32);
    chk("bnd_pend", bus.Pending, 1'b0);
    chk("bnd_hold", bus.HexOut, {G0, G0, G0, G0});
    tick();
    chk("show_12af", bus.HexOut, {G1, G2, GA, GF});

    run_to(36);
    load(16'h0001);
    run_to(38);
    load(16'h00C0);
    run_to(40);
    chk("lw_hold", bus.HexOut, {G1, G2, GA, GF});
    chk("lw_pend", bus.Pending, 1'b1);
    run_to(49);
    chk("last_wins", bus.HexOut, {G0, G0, GC, G0});
    bus.BlankLZ = 1'b1;
    tick();
    chk("blank_lz", bus.HexOut, {BL, BL, GC, G0});

    run_to(51);
    load(16'h0000);
    run_to(65);
    chk("lz_zero", bus.HexOut, {BL, BL, BL, G0});
    chk("lz_pend", bus.Pending, 1'b0);
    bus.BlankLZ = 1'b0;
    tick();
    chk("lz_off", bus.HexOut, {G0, G0, G0, G0});

    run_to(79);
    load(16'h3456);
    chk("edge_pend", bus.Pending, 1'b0);
    chk("edge_hold", bus.HexOut, {G0, G0, G0, G0});
    tick();
    chk("edge_show", bus.HexOut, {G3, G4, G5, G6});

    bus.BlinkEn = 1'b1;
    bus.BlinkMask = 4'b0100;
    tick();
    while (cyc <= 97) begin
      e[3] = G3;
      e[2] = ((((cyc - 1) / 8) % 2) == 0) ? G4 : BL;
      e[1] = G5;
      e[0] = G6;
      chk("blink_hex", bus.HexOut, e);
      chk("blink_seg", bus.ScanSeg, e[((cyc - 1) / 4) % 4]);
      tick();
    end

    bus.BlinkEn = 1'b0;
    load(16'h0F00);
    chk("pre_rst_pend", bus.Pending, 1'b1);
    Reset = 1'b1;
    #1;
    chk("arst_pend", bus.Pending, 1'b0);
    chk("arst_hex", bus.HexOut, 28'hfffffff);
    chk("arst_seg", bus.ScanSeg, BL);
    chk("arst_an", bus.ScanAn, 4'b1111);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc = 0;
    tick();
    chk("rel_an", bus.ScanAn, 4'b1110);
    chk("rel_hex", bus.HexOut, {G0, G0, G0, G0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
